// File: rtl/anneal_run_sequencer.sv
// anneal_run_sequencer
// Autonomous batch sequencer for the anneal control unit. A single start
// command drives RUN/RERUN/RESET through N primary runs, each followed by R
// reruns. It captures the spin read-out at the end of every run/rerun into a
// result FIFO, tagged {run_idx, rerun_idx}.
//
// Optional feature: define SEQ_TIMEOUT_EN to enable a 10-bit ACTIVE-state
// watchdog. When it fires it sets err_timeout and aborts the batch.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   start, abort            one-cycle command pulses
//   cfg_run_count           primary runs per batch (N)
//   cfg_reruns_per_run      reruns after each primary run (R)
//   cfg_gap_cycles          idle cycles between runs (minimum 2 enforced)
//   spin_read_out_valid     read-out strobe from the control unit
//   spin_data               spin vector, qualified by the strobe
//   seq_run/seq_rerun       RUN/RERUN levels to the control unit
//   seq_reset               RESET pulse to the control unit
//   busy, done              status level / completion pulse
//   err_timeout             sticky watchdog flag
//   res_valid/res_ready     result FIFO head handshake
//   res_data/res_tag        result FIFO head payload
module anneal_run_sequencer #(
  parameter int unsigned NUM_SPINS    = 50,
  parameter int unsigned RESULT_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           cfg_run_count,
  input  logic [7:0]           cfg_reruns_per_run,
  input  logic [7:0]           cfg_gap_cycles,
  input  logic                 spin_read_out_valid,
  input  logic [NUM_SPINS-1:0] spin_data,
  output logic                 seq_run,
  output logic                 seq_rerun,
  output logic                 seq_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_SPINS-1:0] res_data,
  output logic [15:0]          res_tag
);

  localparam int unsigned AW = $clog2(RESULT_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;
  localparam int unsigned EW = TW + NUM_SPINS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GAP,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [7:0]      n_q, r_q, g_last_q;
  logic [7:0]      run_idx, rerun_idx, run_idx_n, rerun_idx_n;
  logic [7:0]      gap_cnt;
  logic            aborting;

  logic [EW-1:0]   mem [RESULT_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]   count, count_n;
  logic [EW-1:0]   push_entry;

  logic            timeout_c, abort_take_c, start_take_c, push_c, pop_c;
  logic            last_c, gap_done_c, fifo_full_c;

  // Command qualification
  assign start_take_c = (state == S_IDLE) && start && !abort;
  assign abort_take_c = (state != S_IDLE) && (abort || timeout_c);
  assign push_c       = (state == S_ACTIVE) && spin_read_out_valid && !abort_take_c;
  assign pop_c        = res_valid && res_ready;
  assign last_c       = (run_idx == (n_q - 8'd1)) && (rerun_idx == r_q);
  assign gap_done_c   = (gap_cnt == g_last_q);
  assign fifo_full_c  = (count == CW'(RESULT_DEPTH));
  assign push_entry   = {run_idx, rerun_idx, spin_data};

`ifdef SEQ_TIMEOUT_EN
  logic [9:0] wd_cnt;

  // Watchdog: wd_cnt holds (ACTIVE cycles so far - 1); fires on the 1023rd
  assign timeout_c = (state == S_ACTIVE) && !spin_read_out_valid && (wd_cnt == 10'd1022);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt      <= 10'd0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == S_ACTIVE) ? wd_cnt + 10'd1 : 10'd0;
      if (start_take_c)
        err_timeout <= 1'b0;
      else if (timeout_c)
        err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_c   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and index advance
  always_comb begin
    state_n     = state;
    run_idx_n   = run_idx;
    rerun_idx_n = rerun_idx;
    case (state)
      S_IDLE: begin
        if (start_take_c) begin
          state_n     = S_CLR;
          run_idx_n   = 8'd0;
          rerun_idx_n = 8'd0;
        end
      end
      S_CLR: begin
        if (aborting)
          state_n = S_IDLE;
        else if (n_q == 8'd0)
          state_n = S_DONE;
        else
          state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_done_c && !fifo_full_c)
          state_n = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (push_c) begin
          if (rerun_idx < r_q) begin
            rerun_idx_n = rerun_idx + 8'd1;
          end else begin
            rerun_idx_n = 8'd0;
            run_idx_n   = run_idx + 8'd1;
          end
          state_n = last_c ? S_DONE : S_GAP;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort_take_c)
      state_n = S_CLR;
  end

  // State, config, counters and registered control outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      n_q       <= 8'd0;
      r_q       <= 8'd0;
      g_last_q  <= 8'd1;
      run_idx   <= 8'd0;
      rerun_idx <= 8'd0;
      gap_cnt   <= 8'd0;
      aborting  <= 1'b0;
      seq_run   <= 1'b0;
      seq_rerun <= 1'b0;
      seq_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      run_idx   <= run_idx_n;
      rerun_idx <= rerun_idx_n;
      aborting  <= abort_take_c;
      if (start_take_c) begin
        n_q      <= cfg_run_count;
        r_q      <= cfg_reruns_per_run;
        // Store G-1 with G clamped to at least 2
        g_last_q <= (cfg_gap_cycles < 8'd2) ? 8'd1 : cfg_gap_cycles - 8'd1;
      end
      if ((state_n == S_GAP) && (state != S_GAP))
        gap_cnt <= 8'd0;
      else if ((state == S_GAP) && !gap_done_c)
        gap_cnt <= gap_cnt + 8'd1;
      seq_run   <= (state_n == S_ACTIVE) && (rerun_idx_n == 8'd0);
      seq_rerun <= (state_n == S_ACTIVE) && (rerun_idx_n != 8'd0);
      seq_reset <= (state_n == S_CLR);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

  // FIFO pointer/count next values
  always_comb begin
    rd_ptr_n = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count + CW'(push_c) - CW'(pop_c);
  end

  // FIFO storage (no reset needed; pointers define contents)
  always_ff @(posedge i_clk) begin
    if (push_c)
      mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers and registered head; bypass when the pushed entry becomes head
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      if (push_c)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      res_valid <= (count_n != '0);
      if (count_n != '0) begin
        if (push_c && (wr_ptr == rd_ptr_n))
          {res_tag, res_data} <= push_entry;
        else
          {res_tag, res_data} <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: tb/tb_anneal_run_sequencer.sv
// Directed self-checking bench for anneal_run_sequencer (default build).
module tb_anneal_run_sequencer;

  localparam int unsigned NS = 50;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          start, abort;
  logic [7:0]    cfg_run_count, cfg_reruns_per_run, cfg_gap_cycles;
  logic          spin_read_out_valid;
  logic [NS-1:0] spin_data;
  logic          seq_run, seq_rerun, seq_reset, busy, done, err_timeout;
  logic          res_valid, res_ready;
  logic [NS-1:0] res_data;
  logic [15:0]   res_tag;

  anneal_run_sequencer #(.NUM_SPINS(NS), .RESULT_DEPTH(8)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .start               (start),
    .abort               (abort),
    .cfg_run_count       (cfg_run_count),
    .cfg_reruns_per_run  (cfg_reruns_per_run),
    .cfg_gap_cycles      (cfg_gap_cycles),
    .spin_read_out_valid (spin_read_out_valid),
    .spin_data           (spin_data),
    .seq_run             (seq_run),
    .seq_rerun           (seq_rerun),
    .seq_reset           (seq_reset),
    .busy                (busy),
    .done                (done),
    .err_timeout         (err_timeout),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data),
    .res_tag             (res_tag)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Edge/pulse monitor and popped-result log, sampled mid-cycle
  int run_rises = 0, rerun_rises = 0, reset_rises = 0, done_cnt = 0;
  logic prev_run = 1'b0, prev_rerun = 1'b0, prev_reset = 1'b0;
  logic [15:0]   tag_q[$];
  logic [NS-1:0] data_q[$];

  always @(negedge i_clk) begin
    if (seq_run && !prev_run)     run_rises++;
    if (seq_rerun && !prev_rerun) rerun_rises++;
    if (seq_reset && !prev_reset) reset_rises++;
    if (done) done_cnt++;
    if (res_valid && res_ready) begin
      tag_q.push_back(res_tag);
      data_q.push_back(res_data);
    end
    prev_run   = seq_run;
    prev_rerun = seq_rerun;
    prev_reset = seq_reset;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS-1:0] pat(input int k);
    logic [63:0] v;
    v = 64'h2_55AA_0F0F_3C3C ^ (64'(k) * 64'h0001_0203_0405_0607);
    return NS'(v);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_active(input string tag);
    int n;
    n = 0;
    while (!(seq_run || seq_rerun) && n < 3000) begin
      step();
      n++;
    end
    if (!(seq_run || seq_rerun)) check(tag, 64'(seq_run | seq_rerun), 64'd1);
  endtask

  task automatic pulse_valid(input logic [NS-1:0] d);
    spin_read_out_valid = 1'b1;
    spin_data           = d;
    step();
    spin_read_out_valid = 1'b0;
  endtask

  // Return valid 10 cycles into ACTIVE
  task automatic serve(input string tag, input logic [NS-1:0] d);
    wait_active(tag);
    repeat (9) step();
    pulse_valid(d);
  endtask

  task automatic go(input logic [7:0] n, input logic [7:0] r, input logic [7:0] g);
    cfg_run_count      = n;
    cfg_reruns_per_run = r;
    cfg_gap_cycles     = g;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int qb, rb, rrb, db, sb, lowcnt;
    i_rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cfg_run_count = 8'd0; cfg_reruns_per_run = 8'd0; cfg_gap_cycles = 8'd0;
    spin_read_out_valid = 1'b0; spin_data = '0;
    repeat (3) step();
    i_rst = 1'b0;
    step();

    // Reset state
    check("rst_seq_run", 64'(seq_run), 64'd0);
    check("rst_seq_rerun", 64'(seq_rerun), 64'd0);
    check("rst_seq_reset", 64'(seq_reset), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);

    // Test 1: N=2 R=1 gap=4, consumer always ready
    qb = tag_q.size(); rb = run_rises; rrb = rerun_rises; db = done_cnt;
    res_ready = 1'b1;
    go(8'd2, 8'd1, 8'd4);
    check("t1_clr_seq_reset", 64'(seq_reset), 64'd1);
    check("t1_clr_busy", 64'(busy), 64'd1);
    repeat (4) step();
    check("t1_gap_last_run_low", 64'(seq_run), 64'd0);
    step();
    check("t1_first_run", 64'(seq_run), 64'd1);
    serve("t1_serve0", pat(0));
    check("t1_run_drop", 64'(seq_run), 64'd0);
    check("t1_cap_valid", 64'(res_valid), 64'd1);
    check("t1_cap_tag", 64'(res_tag), 64'h0000);
    check("t1_cap_data", 64'(res_data), 64'(pat(0)));
    serve("t1_serve1", pat(1));
    serve("t1_serve2", pat(2));
    serve("t1_serve3", pat(3));
    check("t1_done", 64'(done), 64'd1);
    step();
    check("t1_busy_clear", 64'(busy), 64'd0);
    check("t1_done_clear", 64'(done), 64'd0);
    step();
    check("t1_pop_count", 64'(tag_q.size() - qb), 64'd4);
    check("t1_tag0", 64'(tag_q[qb]),     64'h0000);
    check("t1_tag1", 64'(tag_q[qb + 1]), 64'h0001);
    check("t1_tag2", 64'(tag_q[qb + 2]), 64'h0100);
    check("t1_tag3", 64'(tag_q[qb + 3]), 64'h0101);
    check("t1_data3", 64'(data_q[qb + 3]), 64'(pat(3)));
    check("t1_run_pulses", 64'(run_rises - rb), 64'd2);
    check("t1_rerun_pulses", 64'(rerun_rises - rrb), 64'd2);
    check("t1_done_pulses", 64'(done_cnt - db), 64'd1);

    // Test 2: N=10 R=0, consumer stalled until FIFO fills
    qb = tag_q.size(); db = done_cnt;
    res_ready = 1'b0;
    go(8'd10, 8'd0, 8'd2);
    for (int k = 0; k < 8; k++) serve("t2_serve", pat(10 + k));
    repeat (20) step();
    check("t2_parked_run_low", 64'(seq_run), 64'd0);
    check("t2_parked_busy", 64'(busy), 64'd1);
    check("t2_parked_head_tag", 64'(res_tag), 64'h0000);
    check("t2_parked_head_data", 64'(res_data), 64'(pat(10)));
    res_ready = 1'b1;
    serve("t2_serve8", pat(18));
    serve("t2_serve9", pat(19));
    check("t2_done", 64'(done), 64'd1);
    repeat (12) step();
    check("t2_pop_count", 64'(tag_q.size() - qb), 64'd10);
    for (int k = 0; k < 10; k++) begin
      check("t2_tag", 64'(tag_q[qb + k]), 64'(k) << 8);
      check("t2_data", 64'(data_q[qb + k]), 64'(pat(10 + k)));
    end
    check("t2_done_pulses", 64'(done_cnt - db), 64'd1);
    check("t2_drained", 64'(res_valid), 64'd0);

    // Test 3: abort (with a coincident valid) during the second ACTIVE
    res_ready = 1'b0;
    db = done_cnt; sb = reset_rises;
    go(8'd2, 8'd0, 8'd2);
    serve("t3_serve0", pat(30));
    wait_active("t3_wait2");
    repeat (3) step();
    abort = 1'b1;
    pulse_valid(pat(31));
    abort = 1'b0;
    check("t3_run_drop", 64'(seq_run), 64'd0);
    check("t3_seq_reset", 64'(seq_reset), 64'd1);
    check("t3_busy_in_clr", 64'(busy), 64'd1);
    step();
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_reset_end", 64'(seq_reset), 64'd0);
    step();
    check("t3_no_done", 64'(done_cnt - db), 64'd0);
    check("t3_reset_pulses", 64'(reset_rises - sb), 64'd2);
    check("t3_head_valid", 64'(res_valid), 64'd1);
    check("t3_head_tag", 64'(res_tag), 64'h0000);
    check("t3_head_data", 64'(res_data), 64'(pat(30)));
    res_ready = 1'b1;
    step();
    step();
    check("t3_one_entry", 64'(res_valid), 64'd0);

    // Test 4: gap=0 clamps to two low cycles between runs
    go(8'd3, 8'd0, 8'd0);
    wait_active("t4_wait0");
    for (int k = 0; k < 3; k++) begin
      pulse_valid(pat(40 + k));
      if (k < 2) begin
        lowcnt = 0;
        while (!seq_run && lowcnt < 100) begin
          lowcnt++;
          step();
        end
        check("t4_low_cycles", 64'(lowcnt), 64'd2);
      end else begin
        check("t4_done", 64'(done), 64'd1);
      end
    end
    repeat (4) step();

    // Test 5: N=0 completes without any run
    rb = run_rises;
    go(8'd0, 8'd0, 8'd5);
    check("t5_seq_reset", 64'(seq_reset), 64'd1);
    check("t5_no_done_yet", 64'(done), 64'd0);
    step();
    check("t5_done", 64'(done), 64'd1);
    check("t5_reset_end", 64'(seq_reset), 64'd0);
    step();
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_run", 64'(run_rises - rb), 64'd0);

    // Test 6: start together with abort in IDLE is ignored
    cfg_run_count = 8'd1;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_seq_reset", 64'(seq_reset), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
